change_hopper_ctrl: RTL and testbench

- Responder side of the vending controller's change/candy interface.
- Consumes level requests give_rs_05/02/01 and single-cycle give_candy pulses.
- Drives per-denomination hopper motors, confirms each coin via drop sensors, and returns a one-cycle rs_xx_out acknowledge per coin.
- Tracks coin inventory per hopper, accepts refills, and reports empty/jam faults.

---
 rtl/change_hopper_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_change_hopper_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_hopper_ctrl.sv
// change_hopper_ctrl
// Responder side of the vending controller's change/candy interface.
// It serves one coin request at a time, with priority Rs5 > Rs2 > Rs1.
// For each request it runs the matching hopper motor until a drop-sensor edge confirms the coin.
// It then returns a one-cycle acknowledge.
// It keeps a saturating inventory counter per hopper and accepts refills.
// It reports empty (01) and jam (10) faults, which hold until fault_clr.
// A separate candy path produces a fixed-width motor window per give_candy pulse and can queue one more.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   give_rs_05/02/01              level coin requests
//   give_candy                    single-cycle candy vend pulse
//   coin_drop_05/02/01            synchronous drop sensors (rising edge = coin)
//   refill_valid/sel/amount       inventory refill (sel 11 ignored)
//   fault_clr                     leave FAULT
//   motor_05/02/01                hopper motors
//   rs_05/02/01_out               one-cycle coin-delivered acknowledges
//   candy_motor                   candy dispenser drive
//   cnt_05/02/01                  inventory counts
//   fault, fault_code             fault flag and cause (00 none, 01 empty, 10 jam)
module change_hopper_ctrl #(
  parameter int CNT_W        = 8,
  parameter int INIT_COUNT   = 20,
  parameter int DROP_TIMEOUT = 255,
  parameter int CANDY_PULSE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             give_rs_05,
  input  logic             give_rs_02,
  input  logic             give_rs_01,
  input  logic             give_candy,
  input  logic             coin_drop_05,
  input  logic             coin_drop_02,
  input  logic             coin_drop_01,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_amount,
  input  logic             fault_clr,
  output logic             motor_05,
  output logic             motor_02,
  output logic             motor_01,
  output logic             rs_05_out,
  output logic             rs_02_out,
  output logic             rs_01_out,
  output logic             candy_motor,
  output logic [CNT_W-1:0] cnt_05,
  output logic [CNT_W-1:0] cnt_02,
  output logic [CNT_W-1:0] cnt_01,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int TMR_W = $clog2(DROP_TIMEOUT + 1);
  localparam int CND_W = $clog2(CANDY_PULSE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DROP_TIMEOUT - 1);
  localparam logic [CND_W-1:0] CND_LAST = CND_W'(CANDY_PULSE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    ACK      = 2'b10,
    FAULT    = 2'b11
  } state_t;

  // A same-cycle refill and decrement give cur - 1 + amt.
  // The result clamps to the counter maximum and never goes below zero.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic dec, input logic add,
                                                  input logic [CNT_W-1:0] amt);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, amt} : {(CNT_W+1){1'b0}});
    if (dec && (sum != {(CNT_W+1){1'b0}})) begin
      sum = sum - {{CNT_W{1'b0}}, 1'b1};
    end
    if (sum > {1'b0, CNT_MAX}) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  // Bit 0 = Rs5, bit 1 = Rs2, bit 2 = Rs1 throughout.
  logic [2:0]       req_s, drop_s, pick_s, dec_s, add_s;
  logic             pick_empty_s;
  logic [2:0]       drop_prev_r, edge_r, sel_r, motor_r, ack_r;
  logic [CNT_W-1:0] cnt_r [3];
  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic             fault_r;
  logic [1:0]       fault_code_r;
  logic             candy_motor_r, candy_pend_r;
  logic [CND_W-1:0] candy_tmr_r;

  assign req_s  = {give_rs_01, give_rs_02, give_rs_05};
  assign drop_s = {coin_drop_01, coin_drop_02, coin_drop_05};

  // Request priority, empty check on the winner, and per-hopper inc/dec strobes.
  always_comb begin
    pick_s = 3'b000;
    if (req_s[0]) begin
      pick_s = 3'b001;
    end else if (req_s[1]) begin
      pick_s = 3'b010;
    end else if (req_s[2]) begin
      pick_s = 3'b100;
    end else begin
      pick_s = 3'b000;
    end
    pick_empty_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pick_empty_s = pick_empty_s | (pick_s[i] & (cnt_r[i] == {CNT_W{1'b0}}));
    end
    dec_s = (state_r == DISPENSE) ? (sel_r & edge_r) : 3'b000;
    case (refill_sel)
      2'b00:   add_s = {2'b00, refill_valid};
      2'b01:   add_s = {1'b0, refill_valid, 1'b0};
      2'b10:   add_s = {refill_valid, 2'b00};
      default: add_s = 3'b000;
    endcase
  end

  // Registered rising-edge detection of the drop sensors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_prev_r <= 3'b000;
      edge_r      <= 3'b000;
    end else begin
      drop_prev_r <= drop_s;
      edge_r      <= drop_s & ~drop_prev_r;
    end
  end

  // Inventory counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) cnt_r[i] <= CNT_INIT;
    end else begin
      for (int i = 0; i < 3; i++) cnt_r[i] <= next_count(cnt_r[i], dec_s[i], add_s[i], refill_amount);
    end
  end

  // Change FSM with registered motor, acknowledge and fault outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      sel_r        <= 3'b000;
      timer_r      <= {TMR_W{1'b0}};
      motor_r      <= 3'b000;
      ack_r        <= 3'b000;
      fault_r      <= 1'b0;
      fault_code_r <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 3'b000;
          if (pick_s != 3'b000) begin
            sel_r <= pick_s;
            if (pick_empty_s) begin
              state_r      <= FAULT;
              fault_r      <= 1'b1;
              fault_code_r <= 2'b01;
            end else begin
              state_r <= DISPENSE;
              motor_r <= pick_s;
              timer_r <= {TMR_W{1'b0}};
            end
          end
        end
        DISPENSE: begin
          if ((sel_r & edge_r) != 3'b000) begin
            state_r <= ACK;
            motor_r <= 3'b000;
            ack_r   <= sel_r;
          end else if (timer_r == TMR_LAST) begin
            state_r      <= FAULT;
            motor_r      <= 3'b000;
            fault_r      <= 1'b1;
            fault_code_r <= 2'b10;
          end else begin
            timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
          end
        end
        ACK: begin
          ack_r   <= 3'b000;
          state_r <= IDLE;
        end
        FAULT: begin
          motor_r <= 3'b000;
          ack_r   <= 3'b000;
          if (fault_clr) begin
            state_r      <= IDLE;
            fault_r      <= 1'b0;
            fault_code_r <= 2'b00;
          end
        end
        default: begin
          state_r      <= IDLE;
          motor_r      <= 3'b000;
          ack_r        <= 3'b000;
          fault_r      <= 1'b0;
          fault_code_r <= 2'b00;
        end
      endcase
    end
  end

  // Candy window generator.
  // A pulse during a window is remembered once and restarts the window seamlessly at its end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      candy_motor_r <= 1'b0;
      candy_pend_r  <= 1'b0;
      candy_tmr_r   <= {CND_W{1'b0}};
    end else if (candy_motor_r) begin
      if (candy_tmr_r == CND_LAST) begin
        candy_tmr_r <= {CND_W{1'b0}};
        if (candy_pend_r) begin
          candy_pend_r <= 1'b0;
        end else if (!give_candy) begin
          candy_motor_r <= 1'b0;
        end
      end else begin
        candy_tmr_r  <= candy_tmr_r + {{(CND_W-1){1'b0}}, 1'b1};
        candy_pend_r <= candy_pend_r | give_candy;
      end
    end else begin
      candy_pend_r  <= 1'b0;
      candy_tmr_r   <= {CND_W{1'b0}};
      candy_motor_r <= give_candy;
    end
  end

  assign motor_05    = motor_r[0];
  assign motor_02    = motor_r[1];
  assign motor_01    = motor_r[2];
  assign rs_05_out   = ack_r[0];
  assign rs_02_out   = ack_r[1];
  assign rs_01_out   = ack_r[2];
  assign candy_motor = candy_motor_r;
  assign cnt_05      = cnt_r[0];
  assign cnt_02      = cnt_r[1];
  assign cnt_01      = cnt_r[2];
  assign fault       = fault_r;
  assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Scoreboard bench for change_hopper_ctrl.
// Stimulus pushes expected coin acknowledges and fault entries.
// A monitor pops and compares them whenever the DUT acknowledges a coin or raises fault.
// Candy windows come from an interval model and are compared every cycle.
// Denomination index d: 0 = Rs5, 1 = Rs2, 2 = Rs1.
module tb_change_hopper_ctrl;
  localparam int MAXC = 255;
  localparam int KA = 0;
  localparam int KF = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic give_rs_05 = 1'b0, give_rs_02 = 1'b0, give_rs_01 = 1'b0, give_candy = 1'b0;
  logic coin_drop_05 = 1'b0, coin_drop_02 = 1'b0, coin_drop_01 = 1'b0;
  logic refill_valid = 1'b0;
  logic [1:0] refill_sel = 2'b00;
  logic [7:0] refill_amount = 8'd0;
  logic fault_clr = 1'b0;
  logic motor_05, motor_02, motor_01, rs_05_out, rs_02_out, rs_01_out, candy_motor, fault;
  logic [7:0] cnt_05, cnt_02, cnt_01;
  logic [1:0] fault_code;

  change_hopper_ctrl dut (
    .clk(clk), .rst(rst), .give_rs_05(give_rs_05), .give_rs_02(give_rs_02), .give_rs_01(give_rs_01),
    .give_candy(give_candy), .coin_drop_05(coin_drop_05), .coin_drop_02(coin_drop_02),
    .coin_drop_01(coin_drop_01), .refill_valid(refill_valid), .refill_sel(refill_sel),
    .refill_amount(refill_amount), .fault_clr(fault_clr), .motor_05(motor_05), .motor_02(motor_02),
    .motor_01(motor_01), .rs_05_out(rs_05_out), .rs_02_out(rs_02_out), .rs_01_out(rs_01_out),
    .candy_motor(candy_motor), .cnt_05(cnt_05), .cnt_02(cnt_02), .cnt_01(cnt_01), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int d; int val; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int inv [3];
  bit env_en [3];
  int env_fixed = 0;
  bit candy_chk = 1'b1;
  bit candy_done = 1'b0;
  bit exp_candy [0:19999];
  int last_start = -1, last_end = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic get_motor(input int d);
    return (d == 0) ? motor_05 : (d == 1) ? motor_02 : motor_01;
  endfunction
  function automatic logic get_ack(input int d);
    return (d == 0) ? rs_05_out : (d == 1) ? rs_02_out : rs_01_out;
  endfunction
  function automatic logic [7:0] get_cnt(input int d);
    return (d == 0) ? cnt_05 : (d == 1) ? cnt_02 : cnt_01;
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 0) give_rs_05 = v; else if (d == 1) give_rs_02 = v; else give_rs_01 = v;
  endtask
  task automatic set_drop(input int d, input logic v);
    if (d == 0) coin_drop_05 = v; else if (d == 1) coin_drop_02 = v; else coin_drop_01 = v;
  endtask

  // Candy model: each pulse yields a 4-cycle window starting the next cycle.
  // During a window, one extra window may be queued behind it; further pulses are lost.
  task automatic candy_pulse(input int c);
    int start;
    bit take;
    take = 1'b1;
    if (last_end < c + 1) start = c + 1;
    else if (last_start <= c) start = last_end + 1;
    else begin start = 0; take = 1'b0; end
    if (take) begin
      for (int j = 0; j < 4; j++) if (start + j < 20000) exp_candy[start + j] = 1'b1;
      last_start = start;
      last_end = start + 3;
    end
  endtask

  // Hopper environment: a running motor gets a drop pulse after a delay.
  initial begin
    int wait_left [3];
    int drop_left [3];
    bit armed [3];
    for (int d = 0; d < 3; d++) begin wait_left[d] = 0; drop_left[d] = 0; armed[d] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (drop_left[d] > 0) begin
          drop_left[d]--;
          if (drop_left[d] == 0) set_drop(d, 1'b0);
        end else if (wait_left[d] > 0) begin
          wait_left[d]--;
          if (wait_left[d] == 0) begin set_drop(d, 1'b1); drop_left[d] = $urandom_range(1, 3); end
        end else if (get_motor(d) && !armed[d] && env_en[d]) begin
          armed[d] = 1'b1;
          wait_left[d] = (env_fixed > 0) ? env_fixed : $urandom_range(1, 6);
        end
        if (!get_motor(d) && drop_left[d] == 0 && wait_left[d] == 0) armed[d] = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every acknowledge or fault entry.
  initial begin
    logic fault_prev;
    logic [2:0] acks;
    exp_t e;
    fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acks = {rs_01_out, rs_02_out, rs_05_out};
        if (acks != 3'b000) begin
          if (sb.size() == 0) check("unexpected_ack", {29'd0, acks}, 32'd0);
          else begin
            e = sb.pop_front();
            check("ack_kind", e.kind, KA);
            check("ack_denom", {29'd0, acks}, 32'd1 << e.d);
            check("ack_cnt", {24'd0, get_cnt(e.d)}, e.val);
          end
        end
        if (fault && !fault_prev) begin
          if (sb.size() == 0) check("unexpected_fault", {30'd0, fault_code}, 32'd0);
          else begin
            e = sb.pop_front();
            check("fault_kind", e.kind, KF);
            check("fault_code", {30'd0, fault_code}, e.val);
            check("fault_motors_off", {29'd0, motor_01, motor_02, motor_05}, 32'd0);
          end
        end
        if (candy_chk && cyc < 20000) check("candy_motor", {31'd0, candy_motor}, {31'd0, exp_candy[cyc]});
      end
      fault_prev = fault;
    end
  end

  // Candy stimulus: directed pulses at relative cycles 0, 2, 3, then random pulses.
  initial begin
    @(posedge rst);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      give_candy = (k == 0 || k == 2 || k == 3);
      if (give_candy) candy_pulse(cyc);
      @(negedge clk);
    end
    for (int k = 0; k < 400; k++) begin
      give_candy = ($urandom_range(0, 7) == 0);
      if (give_candy) candy_pulse(cyc);
      @(negedge clk);
    end
    give_candy = 1'b0;
    repeat (10) @(negedge clk);
    candy_done = 1'b1;
  end

  task automatic wait_ack(input int d, input int bound, output int seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (get_ack(d)) begin seen = 1; break; end
    end
  endtask

  task automatic wait_fault(output int seen);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fault) begin seen = 1; break; end
    end
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_cleared", {29'd0, fault, fault_code}, 32'd0);
  endtask

  task automatic do_coin(input int d);
    int seen;
    if (inv[d] == 0) begin
      sb.push_back('{KF, d, 1});
      set_req(d, 1'b1);
      wait_fault(seen);
      set_req(d, 1'b0);
      check("empty_fault_wait", seen, 1);
      clear_fault();
    end else begin
      inv[d]--;
      sb.push_back('{KA, d, inv[d]});
      set_req(d, 1'b1);
      @(negedge clk);
      check("motor_latency", {31'd0, get_motor(d)}, 32'd1);
      wait_ack(d, 40, seen);
      set_req(d, 1'b0);
      check("ack_wait", seen, 1);
      @(negedge clk);
    end
  endtask

  task automatic refill(input int sel, input int amt);
    refill_valid = 1'b1;
    refill_sel = sel[1:0];
    refill_amount = amt[7:0];
    if (sel < 3) inv[sel] = (inv[sel] + amt > MAXC) ? MAXC : inv[sel] + amt;
    @(negedge clk);
    refill_valid = 1'b0;
    for (int d = 0; d < 3; d++) check("refill_cnt", {24'd0, get_cnt(d)}, inv[d]);
  endtask

  initial begin
    int seen, got, on;
    for (int d = 0; d < 3; d++) begin inv[d] = 20; env_en[d] = 1'b1; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check("reset_cnt", {24'd0, get_cnt(d)}, 20);
    check("reset_outputs", {23'd0, motor_05, motor_02, motor_01, rs_05_out, rs_02_out, rs_01_out,
                            candy_motor, fault, fault_code}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Rs1 with the drop arriving 3 cycles after the motor starts.
    env_fixed = 3;
    do_coin(2);
    env_fixed = 0;

    // Rs2 held across the acknowledge: two coins.
    for (int k = 0; k < 2; k++) begin inv[1]--; sb.push_back('{KA, 1, inv[1]}); end
    set_req(1, 1'b1);
    @(negedge clk);
    check("held_motor", {31'd0, motor_02}, 32'd1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rs_02_out) got++;
      if (got == 2) break;
    end
    set_req(1, 1'b0);
    check("held_acks", got, 2);
    @(negedge clk);

    // Rs5 and Rs1 together: Rs5 wins.
    inv[0]--;
    sb.push_back('{KA, 0, inv[0]});
    set_req(0, 1'b1);
    set_req(2, 1'b1);
    @(negedge clk);
    check("prio_motor", {29'd0, motor_01, motor_02, motor_05}, 32'd1);
    wait_ack(0, 40, seen);
    set_req(0, 1'b0);
    set_req(2, 1'b0);
    check("prio_ack_wait", seen, 1);
    @(negedge clk);

    // Drain Rs5, then an empty fault that survives a refill until fault_clr.
    while (inv[0] > 0) do_coin(0);
    sb.push_back('{KF, 0, 1});
    set_req(0, 1'b1);
    wait_fault(seen);
    check("empty_wait", seen, 1);
    refill(0, 5);
    @(negedge clk);
    check("refill_keeps_fault", {29'd0, fault, fault_code}, 32'd5);
    inv[0]--;
    sb.push_back('{KA, 0, inv[0]});
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    wait_ack(0, 40, seen);
    set_req(0, 1'b0);
    check("after_clr_ack_wait", seen, 1);
    @(negedge clk);

    // Jam: Rs1 motor runs 255 cycles without a drop.
    env_en[2] = 1'b0;
    sb.push_back('{KF, 2, 2});
    set_req(2, 1'b1);
    on = 0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (motor_01) begin on++; set_req(2, 1'b0); end
      if (fault) begin seen = 1; break; end
    end
    check("jam_wait", seen, 1);
    check("jam_motor_cycles", on, 255);
    check("jam_motor_off", {31'd0, motor_01}, 32'd0);
    clear_fault();
    env_en[2] = 1'b1;

    // Bring Rs1 to 10, then refill 250 in the same cycle as the decrement.
    while (inv[2] > 10) do_coin(2);
    env_en[2] = 1'b0;
    inv[2] = MAXC;
    sb.push_back('{KA, 2, MAXC});
    set_req(2, 1'b1);
    @(negedge clk);
    check("sat_motor", {31'd0, motor_01}, 32'd1);
    @(negedge clk);
    coin_drop_01 = 1'b1;
    set_req(2, 1'b0);
    @(negedge clk);
    coin_drop_01 = 1'b0;
    refill_valid = 1'b1;
    refill_sel = 2'b10;
    refill_amount = 8'd250;
    @(negedge clk);
    refill_valid = 1'b0;
    check("sat_ack_seen", {31'd0, rs_01_out}, 32'd1);
    @(negedge clk);
    env_en[2] = 1'b1;

    // Random coins and refills (selector 11 included).
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        refill($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 6));
      do_coin($urandom_range(0, 2));
    end
    for (int d = 0; d < 3; d++) check("final_cnt", {24'd0, get_cnt(d)}, inv[d]);

    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (candy_done) begin seen = 1; break; end
      @(negedge clk);
    end
    check("candy_done_wait", seen, 1);
    candy_chk = 1'b0;

    // Reset in the middle of a dispense.
    env_en[0] = 1'b0;
    set_req(0, 1'b1);
    @(negedge clk);
    check("pre_reset_motor", {31'd0, motor_05}, 32'd1);
    set_req(0, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_motor_off", {31'd0, motor_05}, 32'd0);
    for (int d = 0; d < 3; d++) check("reset_mid_cnt", {24'd0, get_cnt(d)}, 20);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) check("post_reset_cnt", {24'd0, get_cnt(d)}, 20);
    check("post_reset_idle", {29'd0, motor_05, fault, rs_05_out}, 32'd0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
